// File: rtl/ifetch_pkg.sv
// Shared types and constants for the ifetch instruction-fetch stage.
// The halt-on-CBZ-XZR behaviour is enabled by defining IFETCH_HALT_EN.
package ifetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  localparam int                 INSTR_W    = 32;
  localparam logic [2:0]         PC_STEP    = 3'd4;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hb400001f;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word == HALT_INSTR);
  endfunction

endpackage

// File: rtl/ifetch_ifid.sv
// IF/ID pipeline register: synchronous reset, clear (drops valid only),
// load, otherwise hold.
module ifid_reg
  import ifetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [N-1:0]       i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [N-1:0]       o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [N-1:0]       r_pc;

  // Clear has priority over load; instr/pc are kept on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: pc register, FETCH/HALT state and IF/ID register.
// Define IFETCH_HALT_EN to stop fetching on CBZ XZR,#0 (32'hb400001f).
module ifetch
  import ifetch_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [N-1:0]       id_pc,
  output logic               halted
);

  logic [N-1:0] r_pc;
  state_e       r_state;
  logic         r_halted;
  logic         w_fire;
  logic         w_clear;
  logic         w_halt_hit;
  logic [N-1:0] w_pc_inc;
  logic         w_unused_br;

  assign w_fire   = (r_state == FETCH) && !br_taken && (!id_valid || id_ready);
  // A consumed instruction with nothing fetched behind it leaves IF/ID empty.
  assign w_clear  = br_taken || (id_ready && !w_fire);
  assign w_pc_inc = r_pc + {{(N-3){1'b0}}, PC_STEP};
  assign w_unused_br = ^br_target[1:0];

`ifdef IFETCH_HALT_EN
  assign w_halt_hit = is_halt(imem_q);
`else
  assign w_halt_hit = 1'b0;
`endif

  // pc and state: reset beats redirect, redirect beats fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_state  <= FETCH;
      r_halted <= 1'b0;
    end else if (br_taken) begin
      r_pc     <= {br_target[N-1:2], 2'b00};
      r_state  <= FETCH;
      r_halted <= 1'b0;
    end else if (w_fire) begin
      if (w_halt_hit) begin
        r_state  <= HALT;
        r_halted <= 1'b1;
      end else begin
        r_pc <= w_pc_inc;
      end
    end else begin
      r_pc <= r_pc;
    end
  end

  ifid_reg #(.N(N)) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_fire),
    .i_clear (w_clear),
    .i_instr (imem_q),
    .i_pc    (r_pc),
    .o_valid (id_valid),
    .o_instr (id_instr),
    .o_pc    (id_pc)
  );

  assign imem_addr = r_pc[AW+1:2];
  assign halted    = r_halted;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then randomized cycles,
// each cycle compared against a behavioural model of the fetch rules.
module tb_ifetch;

  localparam logic [31:0] HALT_W = 32'hb400001f;
`ifdef IFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_taken;
  logic [63:0] br_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        halted;

  logic [31:0] mem [64];
  assign imem_q = mem[imem_addr];

  always #5 clk = ~clk;

  ifetch #(.N(64), .AW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .halted    (halted)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] m_pc    = 64'd0;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [63:0] m_idpc  = 64'd0;
  bit          m_halt  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit br, input logic [63:0] tgt, input bit rdy);
    logic [31:0] q;
    reset     = r;
    br_taken  = br;
    br_target = tgt;
    id_ready  = rdy;
    q = mem[m_pc[7:2]];
    if (r) begin
      m_pc = 64'd0; m_valid = 1'b0; m_instr = 32'd0; m_idpc = 64'd0; m_halt = 1'b0;
    end else if (br) begin
      m_pc = tgt & ~64'd3; m_valid = 1'b0; m_halt = 1'b0;
    end else if (!m_halt && (!m_valid || rdy)) begin
      m_instr = q; m_idpc = m_pc; m_valid = 1'b1;
      if (HALT_EN && q == HALT_W) m_halt = 1'b1;
      else m_pc = m_pc + 64'd4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("id_valid",  {63'd0, id_valid}, {63'd0, m_valid});
    chk("id_instr",  {32'd0, id_instr}, {32'd0, m_instr});
    chk("id_pc",     id_pc, m_idpc);
    chk("imem_addr", {58'd0, imem_addr}, {58'd0, m_pc[7:2]});
    chk("halted",    {63'd0, halted}, {63'd0, m_halt});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'hf8000001;
    mem[1]  = 32'hf8008002;
    mem[46] = HALT_W;
    reset = 1'b1; br_taken = 1'b0; br_target = 64'd0; id_ready = 1'b0;

    // reset, also overriding a redirect
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 64'h40, 1'b1);
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_addr",  {58'd0, imem_addr}, 64'd0);
    chk("rst_pc",    id_pc, 64'd0);

    // first two fetches
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("w0_instr", {32'd0, id_instr}, 64'hf8000001);
    chk("w0_pc",    id_pc, 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("w1_instr", {32'd0, id_instr}, 64'hf8008002);
    chk("w1_pc",    id_pc, 64'd4);

    // three-cycle stall then release
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b0);
      chk("stall_pc",   id_pc, 64'd4);
      chk("stall_addr", {58'd0, imem_addr}, 64'd2);
    end
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("rel_pc", id_pc, 64'd8);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("rel_pc2", id_pc, 64'd12);

    // redirect during stall, low target bits dropped
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 64'h8A, 1'b0);
    chk("br_valid", {63'd0, id_valid}, 64'd0);
    chk("br_addr",  {58'd0, imem_addr}, 64'h22);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("br_pc", id_pc, 64'h88);

    // imem_addr wrap while pc keeps counting
    step(1'b0, 1'b1, 64'hFC, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("wrap_pc",   id_pc, 64'hFC);
    chk("wrap_addr", {58'd0, imem_addr}, 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("wrap_pc2",  id_pc, 64'h100);

    // halt instruction at word 46
    step(1'b0, 1'b1, 64'hB8, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("halt_pc",    id_pc, 64'hB8);
    chk("halt_instr", {32'd0, id_instr}, {32'd0, HALT_W});
`ifdef IFETCH_HALT_EN
    chk("halt_flag", {63'd0, halted}, 64'd1);
    chk("halt_addr", {58'd0, imem_addr}, 64'd46);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("halt_drop", {63'd0, id_valid}, 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("halt_stay", {58'd0, imem_addr}, 64'd46);
    step(1'b0, 1'b1, 64'h10, 1'b1);
    chk("halt_exit", {63'd0, halted}, 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("resume_pc", id_pc, 64'h10);
    step(1'b0, 1'b1, 64'hB8, 1'b1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
`else
    chk("nohalt_flag", {63'd0, halted}, 64'd0);
    chk("nohalt_addr", {58'd0, imem_addr}, 64'd47);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("nohalt_next", id_pc, 64'hBC);
`endif

    // reset during a stall (and halt, when enabled)
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    chk("rst2_valid", {63'd0, id_valid}, 64'd0);
    chk("rst2_instr", {32'd0, id_instr}, 64'd0);
    chk("rst2_halt",  {63'd0, halted}, 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("rst2_pc",    id_pc, 64'd0);
    chk("rst2_first", {32'd0, id_instr}, 64'hf8000001);

    // randomized traffic
    mem[20] = HALT_W;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter N, default 64, program counter width in bits.
REQ-002 Parameter AW, default 6, instruction memory word-address width (64 words).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_addr  output  AW  word address to instruction memory, equal to pc[AW+1:2].
REQ-006 Port imem_q  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-007 Port br_taken  input  1  redirect request from execute stage.
REQ-008 Port br_target  input  N  byte address to redirect to.
REQ-009 Port id_ready  input  1  decode stage accepts id_instr this cycle.
REQ-010 Port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 Port id_instr  output  32  fetched instruction word.
REQ-012 Port id_pc  output  N  byte address of id_instr.
REQ-013 Port halted  output  1  fetch has stopped on the halt instruction.

Function
REQ-014 Internal pc register SHALL hold a byte address; pc[1:0] SHALL always be 00.
REQ-015 Fetch fires in a cycle when state is FETCH, br_taken=0, and (id_valid=0 or id_ready=1).
REQ-016 On fire: id_instr<=imem_q, id_pc<=pc, id_valid<=1, pc<=pc+4 (modulo 2^N).
REQ-017 When id_valid=1 and id_ready=0 and br_taken=0: pc, id_instr, id_pc, id_valid SHALL hold.
REQ-018 When id_valid=1, id_ready=1 and fetch cannot fire (state HALT): id_valid<=0.
REQ-019 br_taken=1 has priority over stall and fire: pc<={br_target[N-1:2],2'b00}, id_valid<=0, state<=FETCH.
REQ-020 Latency: instruction at pc appears on id_instr exactly one cycle after pc drives imem_addr.
REQ-021 imem_addr wraps every 2^(AW+2) bytes; pc itself wraps only at 2^N; no error raised.
REQ-022 State machine: FETCH (normal), HALT (pc frozen, no fire); HALT exits only on br_taken or reset.

Reset
REQ-023 reset=1 SHALL set pc=0, id_valid=0, id_instr=0, id_pc=0, state=FETCH, halted=0, overriding br_taken.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; first fire after release fetches address 0.

Configuration
REQ-025 Macro IFETCH_HALT_EN defined: on fire with imem_q==32'hb400001f (CBZ XZR,#0), instruction is still delivered, pc does not advance, state<=HALT, halted=1 while in HALT.
REQ-026 Macro IFETCH_HALT_EN undefined: HALT state absent, halted tied to 0, 32'hb400001f fetched like any other word.

Structure
REQ-027 Package ifetch_pkg SHALL hold: state enum (FETCH, HALT), INSTR_W=32, PC_STEP=4, HALT_INSTR=32'hb400001f.
REQ-028 Sub-module ifid_reg SHALL implement the IF/ID register (load, hold, clear); pc and state logic stay in ifetch.

Verification
REQ-029 Reset, id_ready=1, memory word0=f8000001, word1=f8008002 -> cycle1 id_instr=f8000001 id_pc=0; cycle2 id_instr=f8008002 id_pc=4.
REQ-030 id_ready=0 for 3 cycles with id_valid=1 -> id_instr, id_pc, imem_addr unchanged; after release next word follows with no gap or duplicate.
REQ-031 br_taken=1, br_target=0x8A during stall -> next cycle id_valid=0, imem_addr=0x22 (pc=0x88); following cycle id_pc=0x88.
REQ-032 With IFETCH_HALT_EN, word 46=b400001f -> id_pc=0xB8 delivered once, halted=1, pc stays 0xBC-free (imem_addr=46), id_valid drops after accept; br_taken to 0 resumes.
REQ-033 pc=0xFC, fire -> imem_addr becomes 0 (wrap) while id_pc of next word=0x100.
REQ-034 reset pulsed while halted and stalled -> all outputs at reset values next cycle; fetch restarts at 0.
